// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_MUL_LAT = 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIN  = 2'b11
    } state_e;

    // MULT/MULTU/DIV/DIVU all have op[2] clear
    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W cycles total.
// The first iteration is performed on the start edge directly from the input operands.
module muldiv_div_core
    import ex_muldiv_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  q_r, r_r, d_r;
    logic [W-1:0]  q_src, r_src, d_src;
    logic [W-1:0]  q_nx, r_nx;
    logic [W:0]    shifted, diff;
    logic          ge;

    always_comb begin
        r_src   = start ? '0 : r_r;
        q_src   = start ? dividend : q_r;
        d_src   = start ? divisor : d_r;
        shifted = {r_src, q_src[W-1]};
        diff    = shifted - {1'b0, d_src};
        ge      = ~diff[W];
        r_nx    = ge ? diff[W-1:0] : shifted[W-1:0];
        q_nx    = {q_src[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (start) begin
            q_r <= q_nx;
            r_r <= r_nx;
            d_r <= divisor;
            cnt <= CW'(W - 1);
        end else if (busy) begin
            q_r <= q_nx;
            r_r <= r_nx;
            cnt <= cnt - 1'b1;
        end
    end

    assign busy      = (cnt != '0);
    assign quotient  = q_r;
    assign remainder = r_r;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit with MTHI/MTLO writes and pipeline stall request.
// Divider is built only when EX_MULDIV_DIV_EN is defined; otherwise DIV/DIVU complete as no-ops.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src2,
    output logic         busy,
    output logic         stallreq,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNT_W   = $clog2(MUL_LAT + 1);
    localparam int MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    state_e         state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   hi_n, lo_n;
    logic           busy_n, done_n, latch;
    logic           mul_signed;
    logic [2*W-1:0] ext_a, ext_b, prod;

    // Sign- or zero-extending to 2W makes one unsigned multiplier serve both MULT and MULTU
    assign mul_signed = (op_q == OP_MULT);
    assign ext_a      = {{W{mul_signed & a_q[W-1]}}, a_q};
    assign ext_b      = {{W{mul_signed & b_q[W-1]}}, b_q};
    assign prod       = ext_a * ext_b;

`ifdef EX_MULDIV_DIV_EN
    logic         div_start, div_busy;
    logic [W-1:0] dvd_mag, dvs_mag, div_q, div_r, q_fix, r_fix;

    assign dvd_mag = ((op == OP_DIV) && src1[W-1]) ? -src1 : src1;
    assign dvs_mag = ((op == OP_DIV) && src2[W-1]) ? -src2 : src2;

    muldiv_div_core #(.W(W)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .busy      (div_busy),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign q_fix = ((op_q == OP_DIV) && (a_q[W-1] ^ b_q[W-1])) ? -div_q : div_q;
    assign r_fix = ((op_q == OP_DIV) && a_q[W-1]) ? -div_r : div_r;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        hi_n    = hi;
        lo_n    = lo;
        latch   = 1'b0;
`ifdef EX_MULDIV_DIV_EN
        div_start = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            latch   = 1'b1;
                            busy_n  = 1'b1;
                            cnt_n   = CNT_W'(MUL_CNT);
                            state_n = (MUL_LAT == 1) ? S_FIN : S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            latch  = 1'b1;
                            busy_n = 1'b1;
`ifdef EX_MULDIV_DIV_EN
                            div_start = 1'b1;
                            state_n   = S_DIV;
`else
                            state_n   = S_FIN;
`endif
                        end
                        OP_MTHI: hi_n = src1;
                        OP_MTLO: lo_n = src1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt == '0) state_n = S_FIN;
                else           cnt_n   = cnt - 1'b1;
            end
            S_DIV: begin
`ifdef EX_MULDIV_DIV_EN
                if (!div_busy) state_n = S_FIN;
`else
                state_n = S_IDLE;
                busy_n  = 1'b0;
`endif
            end
            S_FIN: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                cnt_n   = '0;
                if (!op_q[1]) begin
                    hi_n = prod[2*W-1:W];
                    lo_n = prod[W-1:0];
                end
`ifdef EX_MULDIV_DIV_EN
                else if (b_q == '0) begin
                    hi_n = a_q;
                    lo_n = '1;
                end else begin
                    hi_n = r_fix;
                    lo_n = q_fix;
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase

        // Kill overrides whatever the state logic decided, including the FIN write
        if (flush && (state != S_IDLE)) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            cnt_n   = '0;
            hi_n    = hi;
            lo_n    = lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            hi    <= hi_n;
            lo    <= lo_n;
            if (latch) begin
                op_q <= op;
                a_q  <= src1;
                b_q  <= src2;
            end
        end
    end

    assign stallreq = busy | (start & (state == S_IDLE) & is_muldiv(op));

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (W=32, MUL_LAT=2); follows EX_MULDIV_DIV_EN if defined.
module tb_ex_muldiv;

    localparam int W       = 32;
    localparam int LAT_MUL = 2;
`ifdef EX_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int LAT_DIV = DIV_EN ? W + 1 : 1;

    logic          clk = 1'b0;
    logic          rst, flush, start;
    logic [2:0]    op;
    logic [W-1:0]  src1, src2, hi, lo;
    logic          busy, stallreq, done;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] hi_m, lo_m;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[12];

    ex_muldiv #(.W(W), .MUL_LAT(LAT_MUL)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .busy     (busy),
        .stallreq (stallreq),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Independent reference: native SV arithmetic on 64-bit values
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'b000: p = sa * sb;
            3'b001: p = {32'h0, a} * {32'h0, b};
            3'b010, 3'b011: begin
                if (!DIV_EN) p = {hi_m, lo_m};
                else if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else if (o == 3'b010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, a};
                else begin
                    if (o == 3'b010) begin
                        q = $signed(a) / $signed(b);
                        r = $signed(a) % $signed(b);
                    end else begin
                        q = a / b;
                        r = a % b;
                    end
                    p = {r, q};
                end
            end
            default: p = {hi_m, lo_m};
        endcase
        return p;
    endfunction

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat, input bit intrude);
        int   k, busy_n, extra;
        bit   seen;
        exp_t e;
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        sbq.push_back('{ehi, elo, elat});
        #1 check({name, " stallreq"}, stallreq, 1);
        @(negedge clk);
        start = 1'b0;
        k = 0; busy_n = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                break;
            end
            if (intrude && k == 0) begin
                start = 1'b1; op = 3'b000; src1 = 32'd100; src2 = 32'd100;
            end
            k++;
            @(negedge clk);
            start = 1'b0;
        end
        check({name, " done_seen"}, seen, 1);
        e = sbq.pop_front();
        check({name, " latency"}, k, e.lat);
        check({name, " busy_cycles"}, busy_n, e.lat);
        check({name, " hi"}, hi, e.hi);
        check({name, " lo"}, lo, e.lo);
        hi_m = e.hi;
        lo_m = e.lo;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({name, " done_single"}, extra, 0);
        check({name, " hi_hold"}, hi, hi_m);
        check({name, " lo_hold"}, lo, lo_m);
    endtask

    task automatic mt_op(input string name, input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        op = o; src1 = a; start = 1'b1;
        #1 check({name, " stallreq"}, stallreq, 0);
        @(negedge clk);
        start = 1'b0;
        if (o == 3'b100) hi_m = a;
        else             lo_m = a;
        check({name, " hi"}, hi, hi_m);
        check({name, " lo"}, lo, lo_m);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " stallreq_after"}, stallreq, 0);
    endtask

    // Flush lands in the at-th busy cycle of the operation
    task automatic flush_run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int at);
        int dcnt;
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < at - 1; k++) @(negedge clk);
        check({name, " busy_before"}, busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check({name, " busy_after"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " hi"}, hi, hi_m);
        check({name, " lo"}, lo, lo_m);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check({name, " no_done"}, dcnt, 0);
        check({name, " hi_hold"}, hi, hi_m);
    endtask

    initial begin
        logic [63:0] p;
        logic [2:0]  o;
        logic [31:0] a, b;
        int dcnt;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
        vecs[2]  = '{3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[3]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{3'b010, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{3'b011, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF};
        vecs[7]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[8]  = '{3'b010, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b011, 32'h100,       32'h7,         32'h4,         32'h24};
        vecs[10] = '{3'b010, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        vecs[11] = '{3'b011, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF};

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'b000; src1 = '0; src2 = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset stallreq", stallreq, 0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] eh, el;
            eh = vecs[i].hi;
            el = vecs[i].lo;
            if (vecs[i].op[1] && !DIV_EN) begin
                eh = hi_m;
                el = lo_m;
            end
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, eh, el,
                  vecs[i].op[1] ? LAT_DIV : LAT_MUL, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            p = model(o, a, b);
            do_op($sformatf("rand%0d", i), o, a, b, p[63:32], p[31:0], o[1] ? LAT_DIV : LAT_MUL, 1'b0);
        end

        mt_op("mthi", 3'b100, 32'h1234);
        mt_op("mtlo", 3'b101, 32'h5678);

        do_op("intrude", 3'b000, 32'd3, 32'd5, 32'h0, 32'd15, LAT_MUL, 1'b1);

        flush_run("flush_mul", 3'b000, 32'd9, 32'd9, 2);
`ifdef EX_MULDIV_DIV_EN
        flush_run("flush_div", 3'b010, 32'hFFFF_FFF9, 32'h2, 10);
`endif
        do_op("post_flush", 3'b000, 32'd6, 32'd7, 32'h0, 32'd42, LAT_MUL, 1'b0);

        // flush with start in IDLE: neither a MUL nor an MTHI is taken
        @(negedge clk);
        op = 3'b000; src1 = 32'd11; src2 = 32'd11; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        op = 3'b100; src1 = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_idle busy", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush_idle no_done", dcnt, 0);
        check("flush_idle hi", hi, hi_m);
        check("flush_idle lo", lo, lo_m);

        // reset in the middle of an operation
        @(negedge clk);
        op = DIV_EN ? 3'b010 : 3'b000; src1 = 32'd77; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid hi", hi, 0);
        check("rst_mid lo", lo, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        hi_m = '0; lo_m = '0;
        do_op("post_rst", 3'b001, 32'd12, 32'd12, 32'h0, 32'd144, LAT_MUL, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter W, default 32: operand and HI/LO width, even, >= 8.
REQ-002 SHALL have parameter MUL_LAT, default 2: multiply latency in cycles, >= 1.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  kill the in-flight op; HI/LO keep their values.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-008 SHALL have port src1  input  W  multiplicand / dividend / MTHI-MTLO data.
REQ-009 SHALL have port src2  input  W  multiplier / divisor.
REQ-010 SHALL have port busy  output  1  registered; high while a MUL/DIV op is in flight.
REQ-011 SHALL have port stallreq  output  1  combinational; busy | (start & IDLE & op is MUL/DIV), drives the pipeline stall controller.
REQ-012 SHALL have port done  output  1  registered single-cycle pulse; high in the cycle new HI/LO values first become visible.
REQ-013 SHALL have ports hi and lo  output  W each  architectural HI/LO registers.

Function
REQ-014 SHALL use FSM states IDLE, MUL, DIV, FIN.
REQ-015 In IDLE with start and no flush, the block SHALL latch op/src1/src2 and go to MUL (MULT/MULTU) or DIV (DIV/DIVU).
REQ-016 Accepted MTHI/MTLO SHALL write src1 to hi/lo at that edge, stay in IDLE, and leave busy, stallreq and done low.
REQ-017 MUL SHALL count MUL_LAT-1 cycles, then go to FIN; the product SHALL be the 2W-bit signed (MULT) or unsigned (MULTU) product, hi = upper W bits, lo = lower W bits.
REQ-018 DIV SHALL run W restoring iterations, one quotient bit per cycle, on operand magnitudes, then go to FIN.
REQ-019 FIN SHALL apply the DIV sign fix: quotient negated if operand signs differ; remainder takes the dividend sign.
REQ-020 FIN SHALL write hi/lo, pulse done on the following cycle, and return to IDLE.
REQ-021 Latency: hi/lo updated and done high MUL_LAT cycles after the accept edge for MUL, and W+1 cycles after it for DIV.
REQ-022 Divisor zero SHALL give lo = all ones and hi = dividend, for both DIV and DIVU, with normal latency.
REQ-023 Signed DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-024 busy SHALL rise on the accept edge and fall on the edge that writes hi/lo.
REQ-025 start while not IDLE SHALL be ignored.
REQ-026 flush in any non-IDLE state SHALL force IDLE at the next edge, with no hi/lo write and no done.
REQ-027 flush together with start in IDLE SHALL win: nothing is accepted.

Reset
REQ-028 On rst, the state SHALL be IDLE and hi, lo, busy, done and all counters SHALL be 0, including mid-operation; rst overrides flush and start.

Configuration
REQ-029 With macro EX_MULDIV_DIV_EN defined, the divider SHALL be built and DIV/DIVU behave per REQ-018..REQ-023.
REQ-030 Without EX_MULDIV_DIV_EN, no divider logic SHALL exist; DIV/DIVU SHALL go straight to FIN, leave hi/lo unchanged, and pulse done 1 cycle after the accept edge.

Structure
REQ-031 A shared package SHALL hold the op encodings, the FSM state encodings, and the MUL_LAT/W defaults.
REQ-032 The iterative restoring divide core SHALL be a sub-module named muldiv_div_core (start/busy/quotient/remainder), instantiated only under EX_MULDIV_DIV_EN.

Verification (W=32, MUL_LAT=2, DIV enabled unless stated)
REQ-033 MULT 0xFFFFFFFF*0x2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 2 cycles after accept; MULTU same operands -> hi=0x1, lo=0xFFFFFFFE.
REQ-034 DIV 0xFFFFFFF9/0x2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done 33 cycles after accept, busy high for exactly 33 cycles.
REQ-035 DIVU 0x5/0x0 -> lo=0xFFFFFFFF, hi=0x5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x0.
REQ-036 Start DIV, flush in the 10th busy cycle -> busy low next cycle, hi/lo unchanged, no done; a later MULT completes normally.
REQ-037 MTHI 0x1234 -> hi=0x1234 next cycle, lo unchanged, stallreq never high; start MULT during busy is ignored; rst mid-DIV -> hi=lo=0, IDLE.
REQ-038 Without EX_MULDIV_DIV_EN: DIV 0x7/0x2 -> done 1 cycle after accept, hi/lo unchanged.
